// File: rtl/comar_nor_arbiter.sv
// Round-robin front end that shares one 2-share COMAR NOR gadget among
// NUM_REQ requesters. It contains the issue register, the fresh-mask LFSR
// with the common-mask register, the tag pipeline and the registered response.
module comar_nor_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OPT     = 0,
  parameter logic [31:0] SEED    = 32'h1ACE_B00C
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_a,
  input  logic [2*NUM_REQ-1:0]       req_b,
  output logic [1:0]                 g_a,
  output logic [1:0]                 g_b,
  output logic [5:0]                 g_r,
  output logic                       g_common_out,
  input  logic [1:0]                 g_c,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [1:0]                 rsp_c,
  output logic                       busy
);

  localparam int unsigned     ID_W     = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            slot_free;
  logic            hs;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;
  int unsigned     idx;

  logic            issue_v_q;
  logic [ID_W-1:0] issue_tag_q;
  logic [1:0]      ga_q;
  logic [1:0]      gb_q;

  logic [2:0]      pipe_v_q;
  logic [ID_W-1:0] pipe_tag_q [3];

  logic [31:0]     lfsr_q;
  logic            cm_q;

  // Round-robin search starting just after the pointer, wrapping cyclically.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    sel_a  = '0;
    sel_b  = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
        sel_a  = req_a[2*idx +: 2];
        sel_b  = req_b[2*idx +: 2];
      end
    end
  end

  // In the optimized gadget mode operands must be held for two cycles, so an
  // issue in the previous cycle blocks a grant in this one.
  always_comb begin
    slot_free = (OPT == 0) ? 1'b1 : ~issue_v_q;
    hs        = found & slot_free;
    req_ready = '0;
    if (hs) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PTR_INIT;
      issue_v_q   <= 1'b0;
      issue_tag_q <= '0;
      ga_q        <= '0;
      gb_q        <= '0;
    end else begin
      issue_v_q <= hs;
      if (hs) begin
        ptr_q       <= winner;
        issue_tag_q <= winner;
        ga_q        <= sel_a;
        gb_q        <= sel_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q      <= '0;
      pipe_tag_q[0] <= '0;
      pipe_tag_q[1] <= '0;
      pipe_tag_q[2] <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_c         <= '0;
    end else begin
      pipe_v_q      <= {pipe_v_q[1:0], issue_v_q};
      pipe_tag_q[0] <= issue_tag_q;
      pipe_tag_q[1] <= pipe_tag_q[0];
      pipe_tag_q[2] <= pipe_tag_q[1];
      rsp_valid     <= pipe_v_q[2];
      if (pipe_v_q[2]) begin
        rsp_id <= pipe_tag_q[2];
        rsp_c  <= g_c;
      end
    end
  end

  // The XOR of g_r[5:2] reduces to lfsr[5], so registering that bit yields
  // next cycle's common output mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      cm_q   <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      cm_q   <= lfsr_q[5];
    end
  end

  assign g_a          = ga_q;
  assign g_b          = gb_q;
  assign g_r          = {lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4] ^ lfsr_q[5], lfsr_q[4:0]};
  assign g_common_out = cm_q;
  assign busy         = issue_v_q | (|pipe_v_q);

endmodule

// File: tb/tb_comar_nor_arbiter.sv
// Scoreboard bench for comar_nor_arbiter with a behavioural NOR gadget model.
module tb_comar_nor_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned OPT  = 0;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [2*NR-1:0] req_a = '0;
  logic [2*NR-1:0] req_b = '0;
  logic [1:0]    g_a, g_b, g_c, rsp_c, rsp_id;
  logic [5:0]    g_r;
  logic          g_common_out, rsp_valid, busy;

  comar_nor_arbiter #(.NUM_REQ(NR), .OPT(OPT), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .g_a(g_a), .g_b(g_b), .g_r(g_r),
    .g_common_out(g_common_out), .g_c(g_c), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  int rsp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Gadget stand-in: three register stages from g_a/g_b to g_c, output
  // re-shared with a fresh random mask each cycle.
  logic d1 = 1'b0, d2 = 1'b0;
  logic [1:0] gc_q = '0;
  bit gm;
  always @(posedge clk) begin
    gm = 1'($urandom);
    d1 <= ~((g_a[0] ^ g_a[1]) | (g_b[0] ^ g_b[1]));
    d2 <= d1;
    gc_q <= {d2 ^ gm, gm};
  end
  assign g_c = gc_q;

  // Mask reference: the polynomial x^32+x^22+x^2+x+1 stepped every cycle.
  logic [31:0] m_lfsr;
  logic [5:0]  m_r;
  bit          prev_ok = 0;
  logic        prev_x;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};

  always @(negedge clk) begin
    if (rst_n) begin
      m_r = {m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[4] ^ m_lfsr[5], m_lfsr[4:0]};
      chk("g_r", g_r, m_r);
      if (prev_ok) chk("common_out", g_common_out, prev_x);
      prev_x  = ^m_r[5:2];
      prev_ok = 1;
    end else begin
      prev_ok = 0;
    end
  end

  typedef struct { int unsigned due; int id; logic res; } exp_t;
  exp_t exp_q[$];

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    bit   busy_exp;
    if (rst_n) begin
      busy_exp = 0;
      foreach (exp_q[i]) if (exp_q[i].due > cyc) busy_exp = 1;
      chk("busy", busy, busy_exp);
      if (rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          chk("rsp_spurious", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_nor", rsp_c[0] ^ rsp_c[1], e.res);
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("rsp_missing", rsp_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // Requester model: per-requester FIFO of {a1,a0,b1,b0} share words.
  logic [3:0]    pbuf [NR][64];
  int            phead [NR];
  int            pcnt  [NR];
  int            m_ptr = NR - 1;
  bit            m_last = 0;
  logic [NR-1:0] last_rdy;
  int            grant_log[$];
  int unsigned   grant_cyc[$];

  task automatic push_op(input int r, input logic [3:0] w);
    if (pcnt[r] < 64) begin
      pbuf[r][(phead[r] + pcnt[r]) % 64] = w;
      pcnt[r]++;
    end
  endtask

  function automatic bit any_pending();
    for (int r = 0; r < NR; r++) if (pcnt[r] > 0) return 1;
    return 0;
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic step();
    int w, idx;
    logic [NR-1:0] er;
    logic [3:0] wd;
    exp_t e;
    for (int r = 0; r < NR; r++) begin
      wd = pbuf[r][phead[r]];
      req_valid[r] = (pcnt[r] > 0);
      req_a[2*r +: 2] = wd[3:2];
      req_b[2*r +: 2] = wd[1:0];
    end
    w = -1;
    if (OPT == 0 || !m_last)
      for (int k = 1; k <= NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (w < 0 && pcnt[idx] > 0) w = idx;
      end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    #1;
    last_rdy = req_ready;
    chk("req_ready", req_ready, er);
    for (int r = 0; r < NR; r++)
      if (req_ready[r]) begin
        grant_log.push_back(r);
        grant_cyc.push_back(cyc);
      end
    if (w >= 0) begin
      wd    = pbuf[w][phead[w]];
      e.due = cyc + 5;
      e.id  = w;
      e.res = ~((wd[3] ^ wd[2]) | (wd[1] ^ wd[0]));
      exp_q.push_back(e);
      phead[w] = (phead[w] + 1) % 64;
      pcnt[w]--;
      m_ptr  = w;
      m_last = 1;
    end else begin
      m_last = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || any_pending()) && n < budget) begin
      step();
      n++;
    end
    #2;
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    req_valid = '0;
    exp_q.delete();
    for (int r = 0; r < NR; r++) begin
      pcnt[r]  = 0;
      phead[r] = 0;
    end
    m_ptr  = NR - 1;
    m_last = 0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    for (int r = 0; r < NR; r++) begin
      phead[r] = 0;
      pcnt[r]  = 0;
      for (int i = 0; i < 64; i++) pbuf[r][i] = '0;
    end
    @(negedge clk);
    apply_reset(3);
    #1;
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_g_a", g_a, 0);
    chk("rst_g_b", g_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (10) step();

    // Fairness: all requesters continuously valid from reset.
    grant_log.delete();
    grant_cyc.delete();
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < 8; i++) push_op(r, 4'($urandom_range(0, 15)));
    drain(200);
    for (int i = 0; i < 8; i++) begin
      chk("fair_order", grant_log[i], i % NR);
      if (i > 0) chk("fair_spacing", grant_cyc[i] - grant_cyc[i-1], OPT + 1);
    end

    // Single op: requester 2, a=01, b=00, NOR result 0.
    rc0 = rsp_count;
    push_op(2, 4'b0100);
    drain(40);
    chk("single_rsp_count", rsp_count - rc0, 1);

    // Exhaustive share pairs from every requester.
    for (int r = 0; r < NR; r++)
      for (int w = 0; w < 16; w++) push_op(r, 4'(w));
    drain(400);

    // Random traffic.
    repeat (1000) begin
      for (int r = 0; r < NR; r++)
        if (pcnt[r] < 8 && $urandom_range(0, 2) == 0) push_op(r, 4'($urandom_range(0, 15)));
      step();
    end
    drain(200);

    // Mid-op reset two cycles after a handshake.
    push_op(2, 4'b0110);
    step();
    step();
    apply_reset(2);
    rc0 = rsp_count;
    repeat (8) step();
    chk("midreset_no_rsp", rsp_count - rc0, 0);
    for (int r = 0; r < NR; r++) push_op(r, 4'($urandom_range(0, 15)));
    step();
    chk("post_reset_grant", last_rdy, 4'b0001);
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
